// File: rtl/fir_feed_pkg.sv
// Shared defaults, fill value and state type for the FIR sample feeder.
package fir_feed_pkg;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_FRAME_CYCLES = 20;

   // Value handed to the filter when a frame finds no sample waiting.
   localparam int UNDERRUN_FILL = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } feed_state_t;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Signal bundle between the feeder, its upstream source and the FIR filter.
// The feeder uses the slave view; whatever surrounds it uses the master view.
interface fir_sample_feeder_if
   import fir_feed_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              enable;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] fir_in;
   logic              fir_ready;
   logic [DATA_W-1:0] fir_out;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              underrun;
   logic              clr_underrun;
   logic [LVL_W-1:0]  fifo_level;

   modport master (
      output enable, in_data, in_valid, fir_out, clr_underrun,
      input  in_ready, fir_in, fir_ready, out_data, out_valid, underrun, fifo_level
   );

   modport slave (
      input  enable, in_data, in_valid, fir_out, clr_underrun,
      output in_ready, fir_in, fir_ready, out_data, out_valid, underrun, fifo_level
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read: rd_data always shows
// the head entry while the FIFO is non-empty. Push when full and pop when
// empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces samples from a FIFO into the FIR filter, one per frame, and strobes
// each filter result out. The first result after every start is dropped
// because the filter's accumulation straddles the start boundary.
//
// state | meaning
// IDLE  | filter not fed, fir_ready low, frame counter held at 0
// RUN   | frame counter cycling; prefetch at cnt=FRAME_CYCLES-2,
//       | filter latches at cnt=FRAME_CYCLES-1 (frame end)
module fir_sample_feeder
   import fir_feed_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
   input  logic               clk,
   input  logic               rst_n,
   fir_sample_feeder_if.slave bus
);
   localparam int CNT_W = $clog2(FRAME_CYCLES);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(FRAME_CYCLES - 2);

   feed_state_t       state;
   feed_state_t       state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              first;
   logic              fe_d;
   logic              frame_end;
   logic              prefetch;
   logic              push;
   logic              pop;
   logic              start;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic [LVL_W-1:0]  level;

   assign frame_end = (state == RUN) && (cnt == CNT_LAST);
   assign prefetch  = (state == RUN) && (cnt == CNT_PRE);
   assign start     = (state == IDLE) && bus.enable;
   assign push      = bus.in_valid && !full;
   assign pop       = prefetch && !empty;

   assign bus.in_ready   = !full;
   assign bus.fifo_level = level;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (bus.in_data),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a stop request only takes effect at a frame end.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.enable) state_nxt = RUN;
         RUN:  if (frame_end && !bus.enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Frame counter and the registered filter ready that follows the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         bus.fir_ready <= 1'b0;
      end else begin
         bus.fir_ready <= (state_nxt == RUN);
         if (state == RUN && state_nxt == RUN) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

   // Prefetch one sample per frame; an empty FIFO feeds the fill value and
   // raises the sticky underrun (a same-cycle clear loses to the set).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.fir_in   <= '0;
         bus.underrun <= 1'b0;
      end else begin
         if (prefetch) begin
            bus.fir_in <= empty ? DATA_W'(UNDERRUN_FILL) : head;
         end
         bus.underrun <= (prefetch && empty) || (bus.underrun && !bus.clr_underrun);
      end
   end

   // Capture the filter result the cycle after it latched its input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fe_d          <= 1'b0;
         first         <= 1'b0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         fe_d          <= frame_end;
         bus.out_valid <= fe_d && !first;
         if (fe_d) begin
            bus.out_data <= bus.fir_out;
         end
         if (start) begin
            first <= 1'b1;
         end else if (fe_d) begin
            first <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder with a small filter model on fir_in/fir_out.
module tb_fir_sample_feeder;
   import fir_feed_pkg::*;

   localparam int DATA_W       = 8;
   localparam int FIFO_DEPTH   = 16;
   localparam int FRAME_CYCLES = 20;

   typedef struct {
      logic [7:0] din;
      logic [4:0] lvl;
      logic       rdy;
   } push_vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   logic [7:0] exp_fir_q [$];
   logic [7:0] exp_out_q [$];
   int         fe_q [$];
   logic [7:0] mdl_prev;

   logic [4:0] f_cnt;
   logic [7:0] h0;
   logic [7:0] h1;

   always #5 clk = ~clk;

   fir_sample_feeder_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   fir_sample_feeder #(
      .DATA_W       (DATA_W),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .FRAME_CYCLES (FRAME_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [7:0] nib_swap(input logic [7:0] v);
      return {v[3:0], v[7:4]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Filter model: own frame counter while ready, latches on the last cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_cnt <= '0;
         h0    <= '0;
         h1    <= '0;
      end else if (!bus.fir_ready) begin
         f_cnt <= '0;
      end else if (f_cnt == 5'(FRAME_CYCLES - 1)) begin
         f_cnt <= '0;
         h0    <= bus.fir_in;
         h1    <= h0;
      end else begin
         f_cnt <= f_cnt + 1'b1;
      end
   end

   assign bus.fir_out = h0 ^ nib_swap(h1);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the sample the filter must latch and, unless it is the first
   // frame after a start, the result it must produce.
   task automatic exp_frame(input logic [7:0] v, input bit first);
      exp_fir_q.push_back(v);
      if (!first) exp_out_q.push_back(v ^ nib_swap(mdl_prev));
      mdl_prev = v;
   endtask

   task automatic apply_push(input push_vec_t v, input int idx);
      bus.in_data  = v.din;
      bus.in_valid = 1'b1;
      tick();
      chk($sformatf("push%0d_level", idx), 32'(bus.fifo_level), 32'(v.lvl));
      chk($sformatf("push%0d_in_ready", idx), 32'(bus.in_ready), 32'(v.rdy));
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_fir_pending"}, exp_fir_q.size(), 0);
      chk({tag, "_out_pending"}, exp_out_q.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_fir_in"}, 32'(bus.fir_in), 0);
      chk({tag, "_fir_ready"}, 32'(bus.fir_ready), 0);
      chk({tag, "_out_data"}, 32'(bus.out_data), 0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_underrun"}, 32'(bus.underrun), 0);
      chk({tag, "_fifo_level"}, 32'(bus.fifo_level), 0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
   endtask

   // Scoreboard: filter latch points and result strobes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.fir_ready && f_cnt == 5'(FRAME_CYCLES - 1)) begin
            fe_q.push_back(cyc);
            if (exp_fir_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL fir_in_latch: unexpected frame end, fir_in %0h", bus.fir_in);
            end else begin
               chk("fir_in_latch", 32'(bus.fir_in), 32'(exp_fir_q.pop_front()));
            end
         end
         if (bus.out_valid) begin
            if (exp_out_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL out_data: unexpected out_valid, out_data %0h", bus.out_data);
            end else begin
               chk("out_data", 32'(bus.out_data), 32'(exp_out_q.pop_front()));
            end
         end
      end
   end

   push_vec_t steady_tbl [3];
   push_vec_t full_tbl [17];

   initial begin
      int start_cyc;
      int drops;

      steady_tbl[0] = '{din: 8'h05, lvl: 5'd1, rdy: 1'b1};
      steady_tbl[1] = '{din: 8'hFB, lvl: 5'd2, rdy: 1'b1};
      steady_tbl[2] = '{din: 8'h7F, lvl: 5'd3, rdy: 1'b1};
      for (int i = 0; i < 17; i++) begin
         full_tbl[i] = '{din: 8'(8'h10 + i), lvl: 5'((i + 1 > 16) ? 16 : i + 1), rdy: 1'(i + 1 < 16)};
      end

      bus.enable       = 1'b0;
      bus.in_data      = '0;
      bus.in_valid     = 1'b0;
      bus.clr_underrun = 1'b0;
      mdl_prev         = '0;

      // Power-on reset.
      #1 rst_n = 1'b0;
      #2 chk_reset_vals("por");
      #9 rst_n = 1'b1;
      tick();

      // Steady stream of three samples, stop requested at cnt=7 of frame 3.
      fe_q.delete();
      for (int i = 0; i < 3; i++) apply_push(steady_tbl[i], i);
      bus.in_valid = 1'b0;
      exp_frame(8'h05, 1'b1);
      exp_frame(8'hFB, 1'b0);
      exp_frame(8'h7F, 1'b0);
      bus.enable = 1'b1;
      tick();
      start_cyc = cyc;
      chk("fir_ready_rise", 32'(bus.fir_ready), 1);
      drops = 0;
      for (int k = 1; k <= 59; k++) begin
         tick();
         if (!bus.fir_ready) drops++;
         if (k == 18) chk("prefetch_before", 32'(bus.fir_in), 0);
         if (k == 19) chk("prefetch_edge", 32'(bus.fir_in), 32'h05);
         if (k == 40) chk("out_valid_k40", 32'(bus.out_valid), 0);
         if (k == 41) chk("out_valid_k41", 32'(bus.out_valid), 1);
         if (k == 42) chk("out_valid_k42", 32'(bus.out_valid), 0);
         if (k == 47) bus.enable = 1'b0;
      end
      chk("fir_ready_held", drops, 0);
      tick();
      chk("fir_ready_fall", 32'(bus.fir_ready), 0);
      tick();
      chk("last_out_valid", 32'(bus.out_valid), 1);
      tick();
      chk("out_valid_single", 32'(bus.out_valid), 0);
      tick(4);
      chk("frame_count", fe_q.size(), 3);
      if (fe_q.size() == 3) begin
         chk("first_frame_end", fe_q[0] - start_cyc, FRAME_CYCLES - 1);
         chk("frame_gap_1", fe_q[1] - fe_q[0], FRAME_CYCLES);
         chk("frame_gap_2", fe_q[2] - fe_q[1], FRAME_CYCLES);
      end
      chk("steady_underrun", 32'(bus.underrun), 0);
      chk_drained("steady");

      // Underrun on an empty FIFO, clear alone, then clear losing to a set.
      exp_frame(8'h00, 1'b1);
      exp_frame(8'h00, 1'b0);
      bus.enable = 1'b1;
      tick();
      tick(18);
      chk("underrun_before", 32'(bus.underrun), 0);
      tick();
      chk("underrun_set", 32'(bus.underrun), 1);
      tick(5);
      bus.clr_underrun = 1'b1;
      tick();
      bus.clr_underrun = 1'b0;
      chk("underrun_clr", 32'(bus.underrun), 0);
      tick(13);
      bus.clr_underrun = 1'b1;
      tick();
      bus.clr_underrun = 1'b0;
      chk("underrun_set_wins", 32'(bus.underrun), 1);
      bus.enable = 1'b0;
      tick();
      chk("underrun_stop", 32'(bus.fir_ready), 0);
      tick(5);
      bus.clr_underrun = 1'b1;
      tick();
      bus.clr_underrun = 1'b0;
      chk("underrun_cleared", 32'(bus.underrun), 0);
      chk_drained("underrun");

      // Fill to full with one extra push, then drain with a push/pop collision.
      for (int i = 0; i < 17; i++) apply_push(full_tbl[i], 100 + i);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 16; i++) exp_frame(8'(8'h10 + i), i == 0);
      exp_frame(8'h99, 1'b0);
      bus.enable = 1'b1;
      tick();
      tick(18);
      chk("full_in_ready_before_pop", 32'(bus.in_ready), 0);
      chk("full_level_before_pop", 32'(bus.fifo_level), 16);
      tick();
      chk("full_in_ready_after_pop", 32'(bus.in_ready), 1);
      chk("full_level_after_pop", 32'(bus.fifo_level), 15);
      tick(299);
      chk("collision_level_before", 32'(bus.fifo_level), 1);
      bus.in_data  = 8'h99;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("collision_level", 32'(bus.fifo_level), 1);
      tick(11);
      bus.enable = 1'b0;
      tick(10);
      chk("full_stop", 32'(bus.fir_ready), 0);
      tick(5);
      chk("full_level_end", 32'(bus.fifo_level), 0);
      chk("full_underrun", 32'(bus.underrun), 0);
      chk_drained("full");

      // Reset in the middle of a frame with state everywhere non-zero.
      bus.in_data  = 8'h3C;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      exp_frame(8'h3C, 1'b1);
      exp_frame(8'h00, 1'b0);
      exp_frame(8'h81, 1'b0);
      bus.enable = 1'b1;
      tick();
      tick(42);
      chk("rst_pre_underrun", 32'(bus.underrun), 1);
      bus.in_data  = 8'h81;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick(18);
      bus.in_data  = 8'h5A;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data  = 8'h66;
      tick();
      bus.in_valid = 1'b0;
      tick(2);
      chk("rst_pre_level", 32'(bus.fifo_level), 2);
      chk("rst_pre_fir_in", 32'(bus.fir_in), 32'h81);
      chk("rst_pre_fir_ready", 32'(bus.fir_ready), 1);
      chk_drained("rst_pre");
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      bus.enable = 1'b0;
      mdl_prev   = '0;
      exp_fir_q.delete();
      exp_out_q.delete();
      rst_n = 1'b1;
      tick(25);
      chk("post_rst_idle", 32'(bus.fir_ready), 0);
      exp_frame(8'h00, 1'b1);
      bus.enable = 1'b1;
      tick();
      tick(19);
      chk("post_rst_fifo_lost", 32'(bus.underrun), 1);
      bus.enable = 1'b0;
      tick(6);
      chk_drained("post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
